// File: rtl/cpu_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding and
// default sizing for the request vector and the cause code.
package cpu_pkg;

    localparam int NUM_IRQ_DEF = 8;
    localparam int CAUSE_W_DEF = $clog2(NUM_IRQ_DEF);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/detector_de_borda.sv
// Rising-edge detector with sticky pending bits for the whole request vector.
// A clear and a new edge on the same bit in the same cycle leaves it pending.
module detector_de_borda #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_irq,
    input  logic [WIDTH-1:0] i_clear,
    output logic [WIDTH-1:0] o_pending
);

    logic [WIDTH-1:0] r_irq_q;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] w_rise;

    assign w_rise = i_irq & ~r_irq_q;

    // Reset captures the live irq levels so lines already high are not seen as edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_q   <= i_irq;
            r_pending <= '0;
        end else begin
            r_irq_q   <= i_irq;
            r_pending <= (r_pending & ~i_clear) | w_rise;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/controlador_de_interrupcao.sv
// Non-nesting interrupt controller: edge-latched requests, lowest index wins.
// Define IRQ_MASK_EN to add a writable per-line mask register.
module controlador_de_interrupcao
    import cpu_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEF,
    parameter int CAUSE_W = CAUSE_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               int_en,
    input  logic               reti,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_data,
    output logic               inta,
    output logic [CAUSE_W-1:0] int_cause,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending
);

    state_t             r_state;
    logic               r_inta;
    logic               r_in_service;
    logic [CAUSE_W-1:0] r_cause;

    logic [NUM_IRQ-1:0] w_pending;
    logic [NUM_IRQ-1:0] w_mask;
    logic [NUM_IRQ-1:0] w_req;
    logic [NUM_IRQ-1:0] w_clear;
    logic [NUM_IRQ-1:0] w_sel_onehot;
    logic [CAUSE_W-1:0] w_sel_idx;
    logic               w_sel_valid;

`ifdef IRQ_MASK_EN
    logic [NUM_IRQ-1:0] r_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '1;
        end else if (mask_we) begin
            r_mask <= mask_data;
        end
    end

    assign w_mask = r_mask;
`else
    logic w_unused_mask;

    assign w_mask        = '1;
    assign w_unused_mask = ^{mask_we, mask_data};
`endif

    detector_de_borda #(
        .WIDTH (NUM_IRQ)
    ) u_detector (
        .clk       (clk),
        .reset     (reset),
        .i_irq     (irq),
        .i_clear   (w_clear),
        .o_pending (w_pending)
    );

    assign w_req = w_pending & w_mask;

    // Scan from the top down so the lowest enabled index is the last to win.
    always_comb begin
        w_sel_idx    = '0;
        w_sel_onehot = '0;
        w_sel_valid  = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_sel_idx       = CAUSE_W'(i);
                w_sel_onehot    = '0;
                w_sel_onehot[i] = 1'b1;
                w_sel_valid     = 1'b1;
            end
        end
    end

    assign w_clear = (r_state == ST_ACK) ? w_sel_onehot : '0;

    // Once in ACK the acknowledge always completes, even if int_en drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_inta       <= 1'b0;
            r_in_service <= 1'b0;
            r_cause      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (int_en && (|w_req)) begin
                        r_state      <= ST_ACK;
                        r_inta       <= 1'b1;
                        r_in_service <= 1'b1;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_SERVICE;
                    r_inta  <= 1'b0;
                    if (w_sel_valid) begin
                        r_cause <= w_sel_idx;
                    end
                end
                ST_SERVICE: begin
                    if (reti) begin
                        r_state      <= ST_IDLE;
                        r_in_service <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_inta       <= 1'b0;
                    r_in_service <= 1'b0;
                end
            endcase
        end
    end

    assign inta       = r_inta;
    assign in_service = r_in_service;
    assign int_cause  = r_cause;
    assign pending    = w_pending;

endmodule

// File: tb/tb_controlador_de_interrupcao.sv
// Scoreboard bench for controlador_de_interrupcao: each expected acknowledge is
// queued at stimulus time and checked by a monitor when inta appears.
module tb_controlador_de_interrupcao;

    logic       clk;
    logic       reset;
    logic [7:0] irq;
    logic       int_en;
    logic       reti;
    logic       mask_we;
    logic [7:0] mask_data;
    logic       inta;
    logic [2:0] int_cause;
    logic       in_service;
    logic [7:0] pending;

    typedef struct {
        int         cyc;
        logic [2:0] cause;
        logic       insvc;
        logic [7:0] pend;
    } exp_t;

    exp_t sb[$];
    int   cyc         = 0;
    int   nCompared   = 0;
    int   nMismatched = 0;

    controlador_de_interrupcao #(
        .NUM_IRQ (8),
        .CAUSE_W (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .int_en     (int_en),
        .reti       (reti),
        .mask_we    (mask_we),
        .mask_data  (mask_data),
        .inta       (inta),
        .int_cause  (int_cause),
        .in_service (in_service),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One call per cycle; values are sampled by the following rising edge.
    task automatic applyStimulus(input logic [7:0] i, input logic en, input logic r);
        @(negedge clk);
        irq     = i;
        int_en  = en;
        reti    = r;
        mask_we = 1'b0;
    endtask

    task automatic writeMask(input logic [7:0] d);
        @(negedge clk);
        mask_we   = 1'b1;
        mask_data = d;
        reti      = 1'b0;
    endtask

    task automatic expectAck(input int c, input logic [2:0] cause, input logic insvc, input logic [7:0] pend);
        exp_t e;
        e.cyc   = c;
        e.cause = cause;
        e.insvc = insvc;
        e.pend  = pend;
        sb.push_back(e);
    endtask

    task automatic serviceDone();
        applyStimulus(8'h00, 1'b1, 1'b1);
        applyStimulus(8'h00, 1'b1, 1'b0);
    endtask

    // Monitor: every inta pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (inta === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected inta", 32'(inta), 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("inta cycle", 32'(cyc), 32'(e.cyc));
                    @(negedge clk);
                    checkOutput("inta width", 32'(inta), 32'd0);
                    checkOutput("int_cause", 32'(int_cause), 32'(e.cause));
                    checkOutput("in_service", 32'(in_service), 32'(e.insvc));
                    checkOutput("pending", 32'(pending), 32'(e.pend));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        irq       = 8'h00;
        int_en    = 1'b0;
        reti      = 1'b0;
        mask_we   = 1'b0;
        mask_data = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset inta", 32'(inta), 32'd0);
        checkOutput("reset in_service", 32'(in_service), 32'd0);
        checkOutput("reset int_cause", 32'(int_cause), 32'd0);
        checkOutput("reset pending", 32'(pending), 32'd0);
        reset = 1'b0;

        // Single edge on irq[5].
        applyStimulus(8'h20, 1'b1, 1'b0);
        expectAck(cyc + 2, 3'd5, 1'b1, 8'h00);
        repeat (4) applyStimulus(8'h20, 1'b1, 1'b0);
        serviceDone();
        checkOutput("idle after reti", 32'(in_service), 32'd0);

        // Bits 3 and 5 together: 3 first, 5 after reti with no new edge.
        applyStimulus(8'h28, 1'b1, 1'b0);
        expectAck(cyc + 2, 3'd3, 1'b1, 8'h20);
        repeat (3) applyStimulus(8'h28, 1'b1, 1'b0);
        applyStimulus(8'h28, 1'b1, 1'b1);
        expectAck(cyc + 2, 3'd5, 1'b1, 8'h00);
        repeat (3) applyStimulus(8'h28, 1'b1, 1'b0);
        serviceDone();

        // reti during ACK is ignored; irq[2] in SERVICE waits for reti.
        applyStimulus(8'h01, 1'b1, 1'b0);
        expectAck(cyc + 2, 3'd0, 1'b1, 8'h00);
        applyStimulus(8'h01, 1'b1, 1'b0);
        applyStimulus(8'h01, 1'b1, 1'b1);
        applyStimulus(8'h05, 1'b1, 1'b0);
        applyStimulus(8'h05, 1'b1, 1'b0);
        applyStimulus(8'h05, 1'b1, 1'b0);
        checkOutput("pending during service", 32'(pending), 32'h04);
        checkOutput("service held", 32'(in_service), 32'd1);
        repeat (2) applyStimulus(8'h05, 1'b1, 1'b0);
        applyStimulus(8'h05, 1'b1, 1'b1);
        expectAck(cyc + 2, 3'd2, 1'b1, 8'h00);
        repeat (3) applyStimulus(8'h05, 1'b1, 1'b0);
        serviceDone();

        // int_en low: request latches but waits.
        applyStimulus(8'h02, 1'b0, 1'b0);
        repeat (3) applyStimulus(8'h02, 1'b0, 1'b0);
        checkOutput("pending while disabled", 32'(pending), 32'h02);
        checkOutput("idle while disabled", 32'(in_service), 32'd0);
        applyStimulus(8'h02, 1'b1, 1'b0);
        expectAck(cyc + 1, 3'd1, 1'b1, 8'h00);
        repeat (3) applyStimulus(8'h02, 1'b1, 1'b0);
        serviceDone();

        // New edge on irq[4] exactly as it is cleared: it stays pending.
        applyStimulus(8'h10, 1'b1, 1'b0);
        expectAck(cyc + 2, 3'd4, 1'b1, 8'h10);
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'h10, 1'b1, 1'b0);
        applyStimulus(8'h10, 1'b1, 1'b0);
        applyStimulus(8'h10, 1'b1, 1'b1);
        expectAck(cyc + 2, 3'd4, 1'b1, 8'h00);
        repeat (3) applyStimulus(8'h10, 1'b1, 1'b0);
        serviceDone();

        // int_en falls in the ACK cycle; acknowledge still completes.
        applyStimulus(8'h40, 1'b1, 1'b0);
        expectAck(cyc + 2, 3'd6, 1'b1, 8'h00);
        applyStimulus(8'h40, 1'b1, 1'b0);
        applyStimulus(8'h40, 1'b0, 1'b0);
        applyStimulus(8'h40, 1'b0, 1'b0);
        serviceDone();

        // Reset in the ACK cycle aborts; irq[6] rising under reset is no edge.
        applyStimulus(8'h80, 1'b1, 1'b0);
        expectAck(cyc + 2, 3'd0, 1'b0, 8'h00);
        applyStimulus(8'h80, 1'b1, 1'b0);
        applyStimulus(8'hC0, 1'b1, 1'b0);
        reset = 1'b1;
        applyStimulus(8'hC0, 1'b1, 1'b0);
        reset = 1'b0;
        repeat (4) applyStimulus(8'hC0, 1'b1, 1'b0);
        checkOutput("no edge after reset", 32'(pending), 32'h00);
        checkOutput("idle after reset", 32'(in_service), 32'd0);

        // Mask 8'hFE then irq[0] edge.
        writeMask(8'hFE);
        applyStimulus(8'hC1, 1'b1, 1'b0);
`ifdef IRQ_MASK_EN
        repeat (3) applyStimulus(8'hC1, 1'b1, 1'b0);
        checkOutput("masked pending", 32'(pending), 32'h01);
        checkOutput("masked idle", 32'(in_service), 32'd0);
        writeMask(8'hFF);
        expectAck(cyc + 2, 3'd0, 1'b1, 8'h00);
        repeat (3) applyStimulus(8'hC1, 1'b1, 1'b0);
`else
        expectAck(cyc + 2, 3'd0, 1'b1, 8'h00);
        repeat (3) applyStimulus(8'hC1, 1'b1, 1'b0);
`endif
        serviceDone();

        repeat (5) applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
        checkOutput("final in_service", 32'(in_service), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/controlador_de_interrupcao.md
CONTROLADOR_DE_INTERRUPCAO -- requirements
Module: controlador_de_interrupcao

Interface
REQ-001 Parameter: NUM_IRQ, default 8, number of interrupt request lines.
REQ-002 Parameter: CAUSE_W, default 3, cause code width, equal to clog2(NUM_IRQ).
REQ-003 Port: clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: irq  input  NUM_IRQ  interrupt requests, rising-edge sensitive.
REQ-006 Port: int_en  input  1  global interrupt enable from the CPU.
REQ-007 Port: reti  input  1  one-cycle pulse: return-from-interrupt executed.
REQ-008 Port: mask_we  input  1  mask write strobe (IRQ_MASK_EN only).
REQ-009 Port: mask_data  input  NUM_IRQ  mask write value, 1 = enabled (IRQ_MASK_EN only).
REQ-010 Port: inta  output  1  interrupt acknowledge pulse to the program counter.
REQ-011 Port: int_cause  output  CAUSE_W  index of the interrupt being serviced.
REQ-012 Port: in_service  output  1  high while an ISR is active.
REQ-013 Port: pending  output  NUM_IRQ  latched, not-yet-acknowledged requests.

Function
REQ-014 Edge detect: the block registers irq as irq_q each cycle; a bit with irq & ~irq_q SHALL set its pending bit at that clock edge.
REQ-015 Pending bits SHALL stay set until acknowledged, regardless of irq falling.
REQ-016 The FSM SHALL have three states: IDLE, ACK, SERVICE.
REQ-017 IDLE -> ACK when int_en=1 and (pending & mask) != 0; otherwise the FSM SHALL remain in IDLE.
REQ-018 ACK lasts exactly one cycle, with inta=1; the FSM then SHALL go to SERVICE.
REQ-019 On the ACK->SERVICE edge, int_cause SHALL load the lowest-index enabled pending bit, and that bit SHALL clear.
REQ-020 SERVICE -> IDLE on reti=1; no nesting: new requests during SERVICE SHALL only set pending bits.
REQ-021 reti SHALL be ignored in IDLE and in ACK.
REQ-022 Simultaneous new edge on the bit being cleared: set SHALL win, and the bit SHALL remain pending.
REQ-023 int_en falling during ACK SHALL NOT cancel the acknowledge in progress.
REQ-024 int_cause SHALL hold its value through SERVICE and until the next ACK.
REQ-025 in_service SHALL be 1 in ACK and SERVICE, 0 in IDLE.
REQ-026 Latency: an irq edge sampled at edge k SHALL produce inta=1 in the cycle after edge k+1, provided the FSM is in IDLE with int_en=1.

Reset
REQ-027 On reset, the FSM SHALL enter IDLE, and inta=0, in_service=0, int_cause=0, pending=0.
REQ-028 On reset, irq_q SHALL load the current irq value, so that levels already high do not register as edges.
REQ-029 Reset during ACK or SERVICE SHALL abort the operation; no inta pulse SHALL complete after reset.

Configuration
REQ-030 Macro IRQ_MASK_EN defined: an internal mask register (reset value all-ones) SHALL be written from mask_data when mask_we=1.
REQ-031 IRQ_MASK_EN defined: masked lines SHALL still latch pending but SHALL NOT trigger ACK.
REQ-032 IRQ_MASK_EN undefined: mask_we and mask_data SHALL be ignored, and mask SHALL be constant all-ones.

Structure
REQ-033 Shared package cpu_pkg SHALL hold the FSM state encoding, the NUM_IRQ default, and the CAUSE_W constant.
REQ-034 A sub-module detector_de_borda SHALL implement edge detection plus pending set/clear, one instance for the full vector.
REQ-035 The priority encoder SHALL be combinational inside the top module; the implementation SHALL be at most 400 lines of RTL.

Verification
REQ-036 Single edge on irq[5] with int_en=1 -> inta pulse of exactly 1 cycle, 2 cycles later; int_cause=5; pending[5]=0.
REQ-037 irq=8'b0010_1000 rising together -> cause 3 serviced first; after reti, cause 5 acknowledged with no further irq edge.
REQ-038 irq[2] edge while in SERVICE -> no inta until reti; inta 2 cycles after reti with int_cause=2.
REQ-039 int_en=0 with irq[1] edge -> pending[1]=1 and no inta; raising int_en -> inta in the following cycle.
REQ-040 Reset asserted in the ACK cycle -> inta=0 and all outputs zero on the next cycle; irq held high produces no new edge.
REQ-041 IRQ_MASK_EN defined, mask=8'hFE, irq[0] edge -> no inta; writing mask=8'hFF -> inta with int_cause=0.
